// File: rtl/puf_sched_pkg.sv
// -----------------------------------------------------------------------------
// puf_pkg: shared types and constants for the PUF scheduler slice.
//   puf_sched_state_e : scheduler FSM states (IDLE, ISSUE, WAIT, RESP)
//   puf_req_t         : latched request (challenge + transaction ID)
//   PUF_TIMEOUT       : default watchdog limit in WAIT cycles
// The struct is sized by PUF_XLEN / TRANS_ID_BITS; instances of puf_sched
// must use XLEN <= PUF_XLEN and TID_W <= TRANS_ID_BITS.
// -----------------------------------------------------------------------------
package puf_pkg;

    localparam int TRANS_ID_BITS = 3;
    localparam int PUF_XLEN      = 64;
    localparam int PUF_TIMEOUT   = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } puf_sched_state_e;

    typedef struct packed {
        logic [PUF_XLEN-1:0]      chal;
        logic [TRANS_ID_BITS-1:0] tid;
    } puf_req_t;

endpackage

// File: rtl/puf_sched_if.sv
// -----------------------------------------------------------------------------
// puf_sched_if: requester-side and core-side signals of the PUF scheduler.
//   slave  : the scheduler (takes requests, drives the core, returns results)
//   master : requesters plus the PUF core (drive requests / core handshake)
//
// Handshakes:
//   request  : req_valid_i[g] && req_ready_o[g] in the same cycle is an accept;
//              a requester holds valid/chal/tid until it sees its ready bit.
//   core     : core_valid_o && core_ready_i is the challenge handshake;
//              core_done_i is a one-cycle result strobe with core_resp_i.
//   response : rsp_valid_o[owner] is a one-cycle strobe, no backpressure;
//              rsp_data_o/rsp_tid_o/rsp_err_o are valid only alongside it.
// -----------------------------------------------------------------------------
interface puf_sched_if
    import puf_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 64,
    parameter int TID_W   = TRANS_ID_BITS
);
    logic                            flush_i;
    logic [NUM_REQ-1:0]              req_valid_i;
    logic [NUM_REQ-1:0]              req_ready_o;
    logic [NUM_REQ-1:0][XLEN-1:0]    req_chal_i;
    logic [NUM_REQ-1:0][TID_W-1:0]   req_tid_i;
    logic [NUM_REQ-1:0]              rsp_valid_o;
    logic [XLEN-1:0]                 rsp_data_o;
    logic [TID_W-1:0]                rsp_tid_o;
    logic                            rsp_err_o;
    logic                            core_valid_o;
    logic                            core_ready_i;
    logic [XLEN-1:0]                 core_chal_o;
    logic                            core_done_i;
    logic [XLEN-1:0]                 core_resp_i;

    modport slave (
        input  flush_i, req_valid_i, req_chal_i, req_tid_i,
        input  core_ready_i, core_done_i, core_resp_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_tid_o, rsp_err_o,
        output core_valid_o, core_chal_o
    );

    modport master (
        output flush_i, req_valid_i, req_chal_i, req_tid_i,
        output core_ready_i, core_done_i, core_resp_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_tid_o, rsp_err_o,
        input  core_valid_o, core_chal_o
    );

endinterface

// File: rtl/puf_sched_rr_arb.sv
// -----------------------------------------------------------------------------
// puf_rr_arb: combinational round-robin pick.
//   i_valid : request vector
//   i_mask  : 1 = requester blocked this cycle
//   i_ptr   : highest-priority index
//   o_grant : one-hot grant (zero when nothing eligible)
//   o_idx   : index of the granted requester
//   o_any   : some requester is granted
// -----------------------------------------------------------------------------
module puf_rr_arb
    import puf_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [NUM_REQ-1:0] i_mask,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);
    logic [NUM_REQ-1:0]   w_elig;
    logic [NUM_REQ-1:0]   w_rot;
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [IDX_W-1:0]     w_off;
    logic [IDX_W:0]       w_sum;

    always_comb begin
        w_elig = i_valid & ~i_mask;
        // Rotate so bit 0 is the requester at the pointer.
        w_dbl  = {w_elig, w_elig} >> i_ptr;
        w_rot  = w_dbl[NUM_REQ-1:0];
        w_off  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = IDX_W'(i);
        end
        // Undo the rotation: index = (ptr + offset) mod NUM_REQ.
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= (IDX_W+1)'(NUM_REQ)) w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
        o_any   = |w_elig;
        o_idx   = w_sum[IDX_W-1:0];
        o_grant = '0;
        if (o_any) o_grant[o_idx] = 1'b1;
    end

endmodule

// File: rtl/puf_sched.sv
// -----------------------------------------------------------------------------
// puf_sched: round-robin scheduler sharing one PUF core among NUM_REQ agents.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : requests, responses and core handshake (puf_sched_if)
//   o_dbg_state  : current FSM state, for observation only
// Requester 0 is flushable via bus.flush_i; the others ignore flush.
// Optional feature macro: PUF_SCHED_TIMEOUT_EN builds the WAIT watchdog.
// -----------------------------------------------------------------------------
module puf_sched
    import puf_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 64,
    parameter int TID_W   = TRANS_ID_BITS,
    parameter int TIMEOUT = PUF_TIMEOUT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    puf_sched_if.slave       bus,
    output puf_sched_state_e o_dbg_state
);
    localparam int IDX_W = $clog2(NUM_REQ);

    puf_sched_state_e   r_state, w_next;
    logic [IDX_W-1:0]   r_ptr, r_owner;
    puf_req_t           r_req;
    logic               r_kill;
    logic [XLEN-1:0]    r_rsp_data;
    logic [TID_W-1:0]   r_rsp_tid;
    logic               r_rsp_err;

    logic [NUM_REQ-1:0] w_grant, w_req_ready, w_rsp_valid;
    logic [IDX_W-1:0]   w_gidx;
    logic               w_gany, w_flush0, w_core_valid, w_hs, w_timeout;

    // Flush only concerns the request currently owned by requester 0.
    assign w_flush0 = bus.flush_i && (r_owner == '0);
    assign w_hs     = w_core_valid && bus.core_ready_i;

    puf_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_valid (bus.req_valid_i),
        .i_mask  (NUM_REQ'(bus.flush_i)),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_gany)
    );

`ifdef PUF_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt, w_cnt_inc;

    // Timeout fires on the TIMEOUT-th WAIT cycle, so WAIT never exceeds it.
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge clk_i) begin
        if (rst_i)                             r_cnt <= '0;
        else if (r_state == ISSUE && w_hs)     r_cnt <= '0;
        else if (r_state == WAIT)              r_cnt <= w_cnt_inc;
    end
`else
    // No watchdog: WAIT exits only on core_done_i; TIMEOUT has no effect.
    assign w_timeout = 1'b0 && (TIMEOUT > 0);
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_gany) w_next = ISSUE;
            ISSUE: begin
                if (w_flush0)              w_next = IDLE;
                else if (bus.core_ready_i) w_next = WAIT;
            end
            WAIT:  if (bus.core_done_i || w_timeout) w_next = RESP;
            RESP:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output logic; a flushed owner-0 request never handshakes or responds.
    always_comb begin
        w_req_ready  = '0;
        w_rsp_valid  = '0;
        w_core_valid = 1'b0;
        if (!rst_i) begin
            if (r_state == IDLE)  w_req_ready  = w_grant;
            if (r_state == ISSUE) w_core_valid = !w_flush0;
            if (r_state == RESP && !r_kill && !w_flush0) w_rsp_valid[r_owner] = 1'b1;
        end
    end

    // Request latch, kill flag, pointer and registered response fields
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr      <= '0;
            r_owner    <= '0;
            r_req      <= '0;
            r_kill     <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_tid  <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_gany) begin
                    r_owner    <= w_gidx;
                    r_req.chal <= PUF_XLEN'(bus.req_chal_i[w_gidx]);
                    r_req.tid  <= TRANS_ID_BITS'(bus.req_tid_i[w_gidx]);
                    r_kill     <= 1'b0;
                end
                WAIT: begin
                    if (w_flush0) r_kill <= 1'b1;
                    // done has priority over a same-cycle timeout
                    if (bus.core_done_i) begin
                        r_rsp_data <= bus.core_resp_i;
                        r_rsp_tid  <= TID_W'(r_req.tid);
                        r_rsp_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_data <= '0;
                        r_rsp_tid  <= TID_W'(r_req.tid);
                        r_rsp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    if (w_flush0) r_kill <= 1'b1;
                    r_ptr <= (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready_o  = w_req_ready;
    assign bus.rsp_valid_o  = w_rsp_valid;
    assign bus.rsp_data_o   = r_rsp_data;
    assign bus.rsp_tid_o    = r_rsp_tid;
    assign bus.rsp_err_o    = r_rsp_err;
    assign bus.core_valid_o = w_core_valid;
    assign bus.core_chal_o  = XLEN'(r_req.chal);
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_puf_sched.sv
// -----------------------------------------------------------------------------
// tb_puf_sched: directed self-checking bench for puf_sched (NUM_REQ=2,
// TIMEOUT=4). The watchdog scenario follows PUF_SCHED_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_puf_sched;
    import puf_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int XLEN    = 64;
    localparam int TID_W   = TRANS_ID_BITS;
    localparam int TIMEOUT = 4;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    puf_sched_state_e dbg_state;
    int               n_cmp = 0;
    int               n_err = 0;

    // bench-side core model: answers chal+1 one cycle after the handshake
    bit               core_auto = 1'b0;
    bit               core_pend = 1'b0;
    logic [XLEN-1:0]  core_lat  = '0;

    puf_sched_if #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .TID_W(TID_W)) bus ();

    puf_sched #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .TID_W(TID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic core_drive();
        if (core_auto) begin
            bus.core_done_i = core_pend;
            bus.core_resp_i = core_pend ? core_lat + 64'd1 : '0;
            core_pend = 1'b0;
        end
    endtask

    task automatic core_track();
        if (core_auto && bus.core_valid_o && bus.core_ready_i) begin
            core_pend = 1'b1;
            core_lat  = bus.core_chal_o;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_i = 1'b1;
        bus.flush_i = 0; bus.req_valid_i = '0; bus.req_chal_i = '0; bus.req_tid_i = '0;
        bus.core_ready_i = 0; bus.core_done_i = 0; bus.core_resp_i = '0;
        repeat (3) tick();
        rst_i = 1'b0;
        settle();
        n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, IDLE); end
        n_cmp++; if (bus.req_ready_o !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b exp 00", bus.req_ready_o); end
        n_cmp++; if (bus.core_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_core_valid: got %b exp 0", bus.core_valid_o); end
        n_cmp++; if (bus.rsp_valid_o !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid: got %b exp 00", bus.rsp_valid_o); end
        n_cmp++; if (bus.rsp_data_o !== 64'h0) begin n_err++; $display("FAIL reset_rsp_data: got %h exp 0", bus.rsp_data_o); end
        n_cmp++; if (bus.rsp_tid_o !== 3'd0) begin n_err++; $display("FAIL reset_rsp_tid: got %0d exp 0", bus.rsp_tid_o); end
        n_cmp++; if (bus.rsp_err_o !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err: got %b exp 0", bus.rsp_err_o); end
    endtask

    task automatic test_single();
        tick();
        bus.req_valid_i = 2'b10; bus.req_chal_i[1] = 64'hA5A5; bus.req_tid_i[1] = 3'd3;
        bus.core_ready_i = 1'b1;
        settle();
        n_cmp++; if (bus.req_ready_o !== 2'b10) begin n_err++; $display("FAIL single_ready: got %b exp 10", bus.req_ready_o); end
        tick(); bus.req_valid_i = '0; settle();
        n_cmp++; if (bus.core_valid_o !== 1'b1) begin n_err++; $display("FAIL single_core_valid: got %b exp 1", bus.core_valid_o); end
        n_cmp++; if (bus.core_chal_o !== 64'hA5A5) begin n_err++; $display("FAIL single_core_chal: got %h exp a5a5", bus.core_chal_o); end
        tick(); bus.core_done_i = 1'b1; bus.core_resp_i = 64'h1234; settle();
        tick(); bus.core_done_i = 1'b0; settle();
        n_cmp++; if (bus.rsp_valid_o !== 2'b10) begin n_err++; $display("FAIL single_rsp_valid: got %b exp 10", bus.rsp_valid_o); end
        n_cmp++; if (bus.rsp_data_o !== 64'h1234) begin n_err++; $display("FAIL single_rsp_data: got %h exp 1234", bus.rsp_data_o); end
        n_cmp++; if (bus.rsp_tid_o !== 3'd3) begin n_err++; $display("FAIL single_rsp_tid: got %0d exp 3", bus.rsp_tid_o); end
        n_cmp++; if (bus.rsp_err_o !== 1'b0) begin n_err++; $display("FAIL single_rsp_err: got %b exp 0", bus.rsp_err_o); end
        tick(); settle();
        n_cmp++; if (bus.rsp_valid_o !== 2'b00) begin n_err++; $display("FAIL single_rsp_one_cycle: got %b exp 00", bus.rsp_valid_o); end
        n_cmp++; if (bus.rsp_data_o !== 64'h1234) begin n_err++; $display("FAIL single_rsp_hold: got %h exp 1234", bus.rsp_data_o); end
    endtask

    task automatic test_contention();
        logic [0:0]      grant_q[$];
        logic [0:0]      own_q[$];
        logic [XLEN-1:0] exp_q[$];
        logic [TID_W-1:0] tid_q[$];
        logic [NUM_REQ-1:0] exp_g;
        logic [0:0]      e;
        int grants = 0;
        int rsps   = 0;
        int cyc    = 0;
        grant_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        own_q   = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_q   = '{64'h101, 64'h201, 64'h101, 64'h201};
        tid_q   = '{3'd1, 3'd2, 3'd1, 3'd2};
        core_auto = 1'b1; core_pend = 1'b0;
        while (rsps < 4 && cyc < 40) begin
            tick();
            core_drive();
            if (cyc == 0) begin
                bus.req_chal_i[0] = 64'h100; bus.req_tid_i[0] = 3'd1;
                bus.req_chal_i[1] = 64'h200; bus.req_tid_i[1] = 3'd2;
                bus.req_valid_i = 2'b11;
            end
            if (grants == 4) bus.req_valid_i = '0;
            settle();
            if (bus.req_ready_o !== 2'b00) begin
                grants++;
                if (grant_q.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL contention_extra_grant: got %b exp none", bus.req_ready_o);
                end else begin
                    e = grant_q.pop_front(); exp_g = '0; exp_g[e] = 1'b1;
                    n_cmp++; if (bus.req_ready_o !== exp_g) begin n_err++; $display("FAIL contention_grant: got %b exp %b", bus.req_ready_o, exp_g); end
                end
            end
            if (bus.rsp_valid_o !== 2'b00) begin
                rsps++;
                if (own_q.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL contention_extra_rsp: got %b exp none", bus.rsp_valid_o);
                end else begin
                    e = own_q.pop_front(); exp_g = '0; exp_g[e] = 1'b1;
                    n_cmp++; if (bus.rsp_valid_o !== exp_g) begin n_err++; $display("FAIL contention_rsp_owner: got %b exp %b", bus.rsp_valid_o, exp_g); end
                    n_cmp++; if (bus.rsp_data_o !== exp_q[0]) begin n_err++; $display("FAIL contention_rsp_data: got %h exp %h", bus.rsp_data_o, exp_q[0]); end
                    n_cmp++; if (bus.rsp_tid_o !== tid_q[0]) begin n_err++; $display("FAIL contention_rsp_tid: got %0d exp %0d", bus.rsp_tid_o, tid_q[0]); end
                    void'(exp_q.pop_front()); void'(tid_q.pop_front());
                end
            end
            core_track();
            cyc++;
        end
        n_cmp++; if (rsps != 4) begin n_err++; $display("FAIL contention_rsp_count: got %0d exp 4", rsps); end
        n_cmp++; if (grants != 4) begin n_err++; $display("FAIL contention_grant_count: got %0d exp 4", grants); end
        core_auto = 1'b0; bus.core_done_i = 1'b0; bus.req_valid_i = '0;
    endtask

    task automatic test_flush_wait();
        tick();
        bus.req_chal_i[0] = 64'h55; bus.req_tid_i[0] = 3'd5;
        bus.req_chal_i[1] = 64'h66; bus.req_tid_i[1] = 3'd6;
        bus.req_valid_i = 2'b11; bus.core_ready_i = 1'b1;
        settle();
        n_cmp++; if (bus.req_ready_o !== 2'b01) begin n_err++; $display("FAIL flushw_grant0: got %b exp 01", bus.req_ready_o); end
        tick(); bus.req_valid_i = 2'b10; settle();
        n_cmp++; if (bus.core_valid_o !== 1'b1) begin n_err++; $display("FAIL flushw_issue: got %b exp 1", bus.core_valid_o); end
        tick(); bus.flush_i = 1'b1; settle();
        tick(); bus.flush_i = 1'b0; settle();
        tick(); bus.core_done_i = 1'b1; bus.core_resp_i = 64'hDEAD; settle();
        tick(); bus.core_done_i = 1'b0; settle();
        n_cmp++; if (bus.rsp_valid_o !== 2'b00) begin n_err++; $display("FAIL flushw_suppressed: got %b exp 00", bus.rsp_valid_o); end
        tick(); settle();
        n_cmp++; if (bus.req_ready_o !== 2'b10) begin n_err++; $display("FAIL flushw_grant1: got %b exp 10", bus.req_ready_o); end
        tick(); bus.req_valid_i = '0; settle();
        n_cmp++; if (bus.core_chal_o !== 64'h66) begin n_err++; $display("FAIL flushw_chal1: got %h exp 66", bus.core_chal_o); end
        tick(); bus.core_done_i = 1'b1; bus.core_resp_i = 64'h77; settle();
        tick(); bus.core_done_i = 1'b0; settle();
        n_cmp++; if (bus.rsp_valid_o !== 2'b10) begin n_err++; $display("FAIL flushw_rsp1_valid: got %b exp 10", bus.rsp_valid_o); end
        n_cmp++; if (bus.rsp_data_o !== 64'h77) begin n_err++; $display("FAIL flushw_rsp1_data: got %h exp 77", bus.rsp_data_o); end
        n_cmp++; if (bus.rsp_tid_o !== 3'd6) begin n_err++; $display("FAIL flushw_rsp1_tid: got %0d exp 6", bus.rsp_tid_o); end
    endtask

    task automatic test_flush_issue();
        bus.core_ready_i = 1'b0;
        tick();
        bus.req_chal_i[0] = 64'h99; bus.req_tid_i[0] = 3'd2; bus.req_valid_i = 2'b01;
        settle();
        n_cmp++; if (bus.req_ready_o !== 2'b01) begin n_err++; $display("FAIL flushi_grant: got %b exp 01", bus.req_ready_o); end
        tick(); bus.req_valid_i = '0; settle();
        tick(); settle();
        n_cmp++; if (bus.core_valid_o !== 1'b1) begin n_err++; $display("FAIL flushi_valid_held: got %b exp 1", bus.core_valid_o); end
        n_cmp++; if (bus.core_chal_o !== 64'h99) begin n_err++; $display("FAIL flushi_chal_held: got %h exp 99", bus.core_chal_o); end
        bus.flush_i = 1'b1;
        tick(); bus.flush_i = 1'b0; settle();
        n_cmp++; if (bus.core_valid_o !== 1'b0) begin n_err++; $display("FAIL flushi_valid_drop: got %b exp 0", bus.core_valid_o); end
        n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL flushi_state: got %0d exp %0d", dbg_state, IDLE); end
        tick(); settle();
        n_cmp++; if (bus.rsp_valid_o !== 2'b00) begin n_err++; $display("FAIL flushi_no_rsp: got %b exp 00", bus.rsp_valid_o); end
        bus.core_ready_i = 1'b1;
    endtask

`ifdef PUF_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int  cyc = 0;
        bit  seen = 1'b0;
        tick();
        bus.req_chal_i[1] = 64'hAB; bus.req_tid_i[1] = 3'd7; bus.req_valid_i = 2'b10;
        settle();
        n_cmp++; if (bus.req_ready_o !== 2'b10) begin n_err++; $display("FAIL timeout_grant: got %b exp 10", bus.req_ready_o); end
        tick(); bus.req_valid_i = '0; settle();
        while (!seen && cyc < 20) begin
            tick();
            bus.flush_i = (cyc == 0);  // flush must not affect owner 1
            settle();
            if (bus.rsp_valid_o !== 2'b00) seen = 1'b1;
            cyc++;
        end
        bus.flush_i = 1'b0;
        n_cmp++; if (bus.rsp_valid_o !== 2'b10) begin n_err++; $display("FAIL timeout_rsp_valid: got %b exp 10", bus.rsp_valid_o); end
        n_cmp++; if (bus.rsp_err_o !== 1'b1) begin n_err++; $display("FAIL timeout_rsp_err: got %b exp 1", bus.rsp_err_o); end
        n_cmp++; if (bus.rsp_data_o !== 64'h0) begin n_err++; $display("FAIL timeout_rsp_data: got %h exp 0", bus.rsp_data_o); end
        n_cmp++; if (bus.rsp_tid_o !== 3'd7) begin n_err++; $display("FAIL timeout_rsp_tid: got %0d exp 7", bus.rsp_tid_o); end
        tick(); bus.core_done_i = 1'b1; bus.core_resp_i = 64'hBAD; settle();
        tick(); bus.core_done_i = 1'b0; settle();
        n_cmp++; if (bus.rsp_valid_o !== 2'b00) begin n_err++; $display("FAIL timeout_late_done: got %b exp 00", bus.rsp_valid_o); end
        tick(); settle();
        n_cmp++; if (bus.rsp_data_o !== 64'h0) begin n_err++; $display("FAIL timeout_data_hold: got %h exp 0", bus.rsp_data_o); end
        n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL timeout_idle: got %0d exp %0d", dbg_state, IDLE); end
    endtask
`else
    task automatic test_no_timeout();
        bit seen = 1'b0;
        tick();
        bus.req_chal_i[1] = 64'hAB; bus.req_tid_i[1] = 3'd7; bus.req_valid_i = 2'b10;
        settle();
        n_cmp++; if (bus.req_ready_o !== 2'b10) begin n_err++; $display("FAIL nowd_grant: got %b exp 10", bus.req_ready_o); end
        tick(); bus.req_valid_i = '0; settle();
        for (int i = 0; i < 12; i++) begin
            tick();
            bus.flush_i = (i == 0);  // flush must not affect owner 1
            settle();
            if (bus.rsp_valid_o !== 2'b00) seen = 1'b1;
        end
        bus.flush_i = 1'b0;
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL nowd_no_early_rsp: got %b exp 0", seen); end
        n_cmp++; if (dbg_state !== WAIT) begin n_err++; $display("FAIL nowd_still_wait: got %0d exp %0d", dbg_state, WAIT); end
        tick(); bus.core_done_i = 1'b1; bus.core_resp_i = 64'hCD; settle();
        tick(); bus.core_done_i = 1'b0; settle();
        n_cmp++; if (bus.rsp_valid_o !== 2'b10) begin n_err++; $display("FAIL nowd_rsp_valid: got %b exp 10", bus.rsp_valid_o); end
        n_cmp++; if (bus.rsp_data_o !== 64'hCD) begin n_err++; $display("FAIL nowd_rsp_data: got %h exp cd", bus.rsp_data_o); end
        n_cmp++; if (bus.rsp_err_o !== 1'b0) begin n_err++; $display("FAIL nowd_rsp_err: got %b exp 0", bus.rsp_err_o); end
        n_cmp++; if (bus.rsp_tid_o !== 3'd7) begin n_err++; $display("FAIL nowd_rsp_tid: got %0d exp 7", bus.rsp_tid_o); end
    endtask
`endif

    task automatic test_reset_wait();
        tick();
        bus.req_chal_i[0] = 64'h11; bus.req_tid_i[0] = 3'd1; bus.req_valid_i = 2'b01;
        bus.core_ready_i = 1'b1;
        settle();
        n_cmp++; if (bus.req_ready_o !== 2'b01) begin n_err++; $display("FAIL rstw_grant: got %b exp 01", bus.req_ready_o); end
        tick(); bus.req_valid_i = '0; settle();
        tick(); settle();
        n_cmp++; if (dbg_state !== WAIT) begin n_err++; $display("FAIL rstw_in_wait: got %0d exp %0d", dbg_state, WAIT); end
        rst_i = 1'b1;
        tick(); rst_i = 1'b0; bus.core_done_i = 1'b1; bus.core_resp_i = 64'h22; settle();
        n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL rstw_state: got %0d exp %0d", dbg_state, IDLE); end
        n_cmp++; if (bus.core_valid_o !== 1'b0) begin n_err++; $display("FAIL rstw_core_valid: got %b exp 0", bus.core_valid_o); end
        n_cmp++; if (bus.rsp_data_o !== 64'h0) begin n_err++; $display("FAIL rstw_rsp_data: got %h exp 0", bus.rsp_data_o); end
        n_cmp++; if (bus.rsp_tid_o !== 3'd0) begin n_err++; $display("FAIL rstw_rsp_tid: got %0d exp 0", bus.rsp_tid_o); end
        n_cmp++; if (bus.rsp_err_o !== 1'b0) begin n_err++; $display("FAIL rstw_rsp_err: got %b exp 0", bus.rsp_err_o); end
        tick(); bus.core_done_i = 1'b0; settle();
        n_cmp++; if (bus.rsp_valid_o !== 2'b00) begin n_err++; $display("FAIL rstw_no_rsp: got %b exp 00", bus.rsp_valid_o); end
        n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL rstw_idle: got %0d exp %0d", dbg_state, IDLE); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_contention();
        test_flush_wait();
        test_flush_issue();
`ifdef PUF_SCHED_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
